// File: rtl/stack_pkg.sv
// Shared definitions for the 4-slot stack: slot count, occupancy state and the
// count -> thermometer enable mapping that the occupancy decoder inverts.
package stack_pkg;

  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } stack_state_e;

  // Thermometer code: one enable bit per occupied slot, filled from bit 0 up.
  // Counts above DEPTH cannot occur; they saturate to all-ones.
  function automatic logic [3:0] count_to_enable(input logic [2:0] count);
    logic [3:0] en;
    case (count)
      3'd0:    en = 4'b0000;
      3'd1:    en = 4'b0001;
      3'd2:    en = 4'b0011;
      3'd3:    en = 4'b0111;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  function automatic stack_state_e count_to_state(input logic [2:0] count);
    stack_state_e st;
    if (count == 3'd0)
      st = EMPTY;
    else if (count >= 3'(DEPTH))
      st = FULL;
    else
      st = PARTIAL;
    return st;
  endfunction

endpackage

// File: rtl/stack_thermo_enc.sv
// Combinational count -> thermometer enable encoder for the stack occupancy vector.
// Ports:
//   count   in  3  entry count, 0..4
//   enable  out 4  thermometer-coded slot occupancy
module stack_thermo_enc
  import stack_pkg::*;
(
  input  logic [2:0] count,
  output logic [3:0] enable
);

  assign enable = count_to_enable(count);

endmodule

// File: rtl/stack_slot_ctrl.sv
// Write-side controller for the 4-slot stack. Accepts push/pop requests, holds
// the slot data and drives registered count, thermometer enable and top-of-stack.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   push       in   1      push request
//   pop        in   1      pop request
//   data_in    in   WIDTH  value written on an accepted push / replace
//   data_out   out  WIDTH  registered top-of-stack value (0 when empty)
//   enable     out  4      registered thermometer occupancy vector
//   count      out  3      registered entry count, 0..4
//   full       out  1      count == 4
//   empty      out  1      count == 0
//   overflow   out  1      one-cycle pulse: push refused while full
//   underflow  out  1      one-cycle pulse: pop refused while empty
// The slot count is fixed by stack_pkg::DEPTH; enable/count widths follow from it.
module stack_slot_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       enable,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] slots [DEPTH];

  stack_state_e     state;
  logic [2:0]       count_nx;
  logic [3:0]       enable_nx;
  logic [WIDTH-1:0] data_out_nx;
  logic             overflow_nx;
  logic             underflow_nx;
  logic             wr_en;
  logic [1:0]       wr_idx;

  assign state = count_to_state(count);
  assign full  = (state == FULL);
  assign empty = (state == EMPTY);

  // Next-state decision: every output below is registered on the same edge.
  always_comb begin
    count_nx     = count;
    data_out_nx  = data_out;
    overflow_nx  = 1'b0;
    underflow_nx = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = 2'd0;

    if (push && !pop) begin
      if (state == FULL) begin
        overflow_nx = 1'b1;
      end else begin
        wr_en       = 1'b1;
        wr_idx      = count[1:0];
        count_nx    = count + 3'd1;
        data_out_nx = data_in;
      end
    end else if (pop && !push) begin
      if (state == EMPTY) begin
        underflow_nx = 1'b1;
      end else begin
        count_nx = count - 3'd1;
        // New top is the slot below the one being popped; nothing left reads as 0.
        if (count >= 3'd2)
          data_out_nx = slots[2'(count - 3'd2)];
        else
          data_out_nx = '0;
      end
    end else if (push && pop) begin
      // Simultaneous push/pop replaces the top; on an empty stack it is a plain push.
      wr_en       = 1'b1;
      data_out_nx = data_in;
      if (state == EMPTY) begin
        wr_idx   = 2'd0;
        count_nx = 3'd1;
      end else begin
        wr_idx   = 2'(count - 3'd1);
      end
    end
  end

  stack_thermo_enc u_enc (
    .count  (count_nx),
    .enable (enable_nx)
  );

  // Register stage: count, enable, top-of-stack, pulses and slot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 3'd0;
      enable    <= 4'b0000;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        slots[i] <= '0;
    end else begin
      count     <= count_nx;
      enable    <= enable_nx;
      data_out  <= data_out_nx;
      overflow  <= overflow_nx;
      underflow <= underflow_nx;
      if (wr_en)
        slots[wr_idx] <= data_in;
    end
  end

endmodule
